pio_bcd_display: RTL and testbench
==================================

# pio_bcd_display

Downstream consumer of the 18-bit Avalon-MM PIO output port. It converts the unsigned binary value on the port to packed BCD with a sequential double-dabble engine and drives six seven-segment displays. Optional leading-zero blanking is supported. The block sits between the PIO peripheral's `out_port` and the board HEX display pins. It re-converts only when the port value changes.

## Interface
Parameters:
- `DATA_W`, 18: width of the binary input.
- `DIGITS`, 6: number of decimal digits and displays. Elaboration fails unless 10^DIGITS > 2^DATA_W − 1.
- `ACTIVE_LOW`, 1: when 1, a lit segment drives 0; when 0, a lit segment drives 1.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `value_in`  in  DATA_W  binary value from the PIO `out_port`. Assumed synchronous to `clk`.
- `blank_lz`  in  1  1 = blank leading-zero digits.
- `bcd_out`  out  4*DIGITS  packed BCD result; digit 0 in bits [3:0].
- `hex`  out  7*DIGITS  segment outputs; digit k in bits [7k+6:7k], order gfedcba, bit 0 = a.
- `busy`  out  1  high while a conversion is in flight.

## Operation
- Registers:
  - `last_val` (DATA_W): value last captured for conversion.
  - `shift` (DATA_W).
  - `bcd_work` (4*DIGITS).
  - `cnt`: ceil(log2(DATA_W+1)) bits.
  - `force`: 1 bit.
  - `state`.
- FSM states are IDLE, CONVERT and DONE.
- IDLE:
  - If `force` = 1, or `value_in` ≠ `last_val`, then load `last_val` and `shift` from `value_in`, clear `bcd_work`, set `cnt` = DATA_W, clear `force`, and go to CONVERT.
  - Otherwise stay in IDLE.
- CONVERT, once per cycle:
  - Every BCD nibble ≥ 5 gets +3, all nibbles in parallel.
  - Then {bcd_work, shift} shifts left by 1.
  - `cnt` decrements. When `cnt` reaches 0 after the decrement, go to DONE.
- DONE:
  - `bcd_out` ← `bcd_work`.
  - `hex` ← encoding of `bcd_work` with `blank_lz` sampled this cycle.
  - Go to IDLE.
- Encoding: digits 0–9 use standard seven-segment patterns. Nibble values 10–15 must be unreachable; if one occurs, drive blank.
- Leading-zero blanking:
  - When `blank_lz` = 1, a digit k ≥ 1 is blank if it and all higher digits are 0.
  - Digit 0 is never blanked, so value 0 displays "0".
- `value_in` changes during CONVERT or DONE are ignored for the current conversion. The IDLE compare on return picks up the new value, so conversions run back to back.
- Intermediate stable values are displayed; no result is skipped once its conversion has started.

## Timing
- Reset values:
  - `bcd_out` = 0.
  - `hex` = all segments off: all 1s when ACTIVE_LOW = 1, all 0s otherwise.
  - `busy` = 0, `state` = IDLE, `last_val` = 0, `force` = 1.
- Reset deasserted mid-conversion: all in-flight state is discarded. The first IDLE cycle after reset converts the current `value_in` because `force` = 1.
- Latency: `value_in` changes before edge E0.
  - E0: IDLE → CONVERT.
  - E1..E(DATA_W): the DATA_W iterations; state → DONE at E(DATA_W).
  - E(DATA_W+1): outputs update.
  - Total is DATA_W+2 edges (20 at defaults).
- `busy` is registered: 1 from after E0 through E(DATA_W+1), then 0. A back-to-back conversion raises it again at the next edge.
- Throughput is one conversion per DATA_W+2 cycles.
- `bcd_out` and `hex` update in the same cycle and never glitch between conversions.

## Structure
- Package `pio_display_pkg` holds:
  - the state enum (IDLE, CONVERT, DONE);
  - 7-bit active-high segment constants SEG_0..SEG_9 and SEG_BLANK;
  - the digit-count check function.
- Sub-module `seg7_encode`: combinational; 4-bit digit plus blank flag in, 7-bit active-high segments out. Instantiated DIGITS times. ACTIVE_LOW inversion is applied in the parent before the output register.

## Test plan
- Reset with `value_in` = 0, `blank_lz` = 1 → 20 cycles after reset release, `bcd_out` = 0x000000, `hex[6:0]` = 7'b1000000, `hex[41:7]` all 1s, `busy` back to 0.
- `value_in` = 262143, `blank_lz` = 0 → after 20 cycles, `bcd_out` = 0x262143 and `hex` shows 2,6,2,1,4,3 (digit 5 down to 0).
- `value_in` = 1234, `blank_lz` = 1 → `bcd_out` = 0x001234; digits 5–4 blank; digit 0 = 4 (7'b0011001).
- `value_in` = 100, then 999 applied 5 cycles into the conversion:
  - first conversion gives `bcd_out` = 0x000100;
  - `busy` drops for at most 1 cycle;
  - second conversion gives 0x000999.
- Same value held or rewritten unchanged → no conversion starts; `busy` stays 0 and outputs are stable for 100 cycles.
- `reset_n` asserted 7 cycles into converting 4321 → outputs immediately return to reset values. After release, one conversion of the held value yields 0x004321.

Source files
------------

// File: rtl/pio_display_pkg.sv
// Shared types and constants for the PIO BCD display block: conversion FSM
// states, active-high seven-segment patterns (gfedcba, bit 0 = a) and the
// elaboration-time check that DIGITS decimal digits can hold DATA_W bits.
package pio_display_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // True when 10^digits exceeds the largest data_w-bit unsigned value.
   function automatic bit digits_cover(input int data_w, input int digits);
      longint unsigned p10;
      longint unsigned max_val;
      p10 = 64'd1;
      for (int i = 0; i < digits; i++) begin
         p10 = p10 * 64'd10;
      end
      max_val = (64'd1 << data_w) - 64'd1;
      return (p10 > max_val);
   endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD digit to active-high seven-segment encoder. Nibble
// values 10-15 never come out of a correct conversion and show blank.
module seg7_encode
   import pio_display_pkg::*;
(
   input  logic [3:0] digit_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   // Digit lookup with blanking taking priority.
   always_comb begin
      seg_o = SEG_BLANK;
      if (!blank_i) begin
         case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/pio_bcd_display.sv
// Converts the PIO output value to packed BCD with a one-bit-per-cycle
// double-dabble engine and drives DIGITS seven-segment displays, with
// optional leading-zero blanking. A conversion starts only when the input
// differs from the last captured value (or once after reset).
//
// Handshake: there is no valid/ready pair. busy is a registered status that
// is high from the edge a conversion is accepted until the edge on which
// bcd_out/hex load the result; the input is sampled only in IDLE.
module pio_bcd_display
   import pio_display_pkg::*;
#(
   parameter int DATA_W     = 18,
   parameter int DIGITS     = 6,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_W-1:0]     value_in,
   input  logic                  blank_lz,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [7*DIGITS-1:0]   hex,
   output logic                  busy,
   output logic [1:0]            state_dbg
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int CAT_W = 4 * DIGITS + DATA_W;

   localparam logic [7*DIGITS-1:0] HEX_OFF = ACTIVE_LOW ? {7*DIGITS{1'b1}} : {7*DIGITS{1'b0}};

   if (!digits_cover(DATA_W, DIGITS)) begin : g_bad_digits
      $error("pio_bcd_display: DIGITS too small for DATA_W");
   end

   state_t                state_q, state_d;
   logic [DATA_W-1:0]     last_val_q, last_val_d;
   logic [DATA_W-1:0]     shift_q, shift_d;
   logic [4*DIGITS-1:0]   bcd_work_q, bcd_work_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  force_q, force_d;
   logic                  busy_q, busy_d;
   logic [4*DIGITS-1:0]   bcd_out_q, bcd_out_d;
   logic [7*DIGITS-1:0]   hex_q, hex_d;

   logic [4*DIGITS-1:0]   bcd_adj;
   logic [CAT_W-1:0]      cat_shifted;
   logic [DIGITS:0]       zero_from;
   logic [DIGITS-1:0]     digit_blank;
   logic [7*DIGITS-1:0]   seg_act;
   logic [7*DIGITS-1:0]   hex_enc;

   // Double-dabble correction: every nibble >= 5 gets +3 in parallel.
   always_comb begin
      bcd_adj = bcd_work_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (bcd_work_q[4*k +: 4] >= 4'd5) begin
            bcd_adj[4*k +: 4] = bcd_work_q[4*k +: 4] + 4'd3;
         end
      end
      cat_shifted = {bcd_adj, shift_q} << 1;
   end

   // Leading-zero blanking: digit k >= 1 blanks when it and all higher digits are zero.
   always_comb begin
      zero_from         = '0;
      digit_blank       = '0;
      zero_from[DIGITS] = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_from[k] = zero_from[k+1] & (bcd_work_q[4*k +: 4] == 4'd0);
      end
      for (int k = 1; k < DIGITS; k++) begin
         digit_blank[k] = blank_lz & zero_from[k];
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_enc
      seg7_encode u_enc (
         .digit_i (bcd_work_q[4*g +: 4]),
         .blank_i (digit_blank[g]),
         .seg_o   (seg_act[7*g +: 7])
      );
   end

   assign hex_enc = ACTIVE_LOW ? ~seg_act : seg_act;

   // Next-state and datapath updates for the IDLE/CONVERT/DONE sequence.
   always_comb begin
      state_d    = state_q;
      last_val_d = last_val_q;
      shift_d    = shift_q;
      bcd_work_d = bcd_work_q;
      cnt_d      = cnt_q;
      force_d    = force_q;
      bcd_out_d  = bcd_out_q;
      hex_d      = hex_q;
      case (state_q)
         IDLE: begin
            if (force_q || (value_in != last_val_q)) begin
               last_val_d = value_in;
               shift_d    = value_in;
               bcd_work_d = '0;
               cnt_d      = CNT_W'(DATA_W);
               force_d    = 1'b0;
               state_d    = CONVERT;
            end
         end
         CONVERT: begin
            bcd_work_d = cat_shifted[CAT_W-1:DATA_W];
            shift_d    = cat_shifted[DATA_W-1:0];
            cnt_d      = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bcd_out_d = bcd_work_q;
            hex_d     = hex_enc;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and datapath registers; reset discards any in-flight conversion.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         last_val_q <= '0;
         shift_q    <= '0;
         bcd_work_q <= '0;
         cnt_q      <= '0;
         force_q    <= 1'b1;
         busy_q     <= 1'b0;
         bcd_out_q  <= '0;
         hex_q      <= HEX_OFF;
      end else begin
         state_q    <= state_d;
         last_val_q <= last_val_d;
         shift_q    <= shift_d;
         bcd_work_q <= bcd_work_d;
         cnt_q      <= cnt_d;
         force_q    <= force_d;
         busy_q     <= busy_d;
         bcd_out_q  <= bcd_out_d;
         hex_q      <= hex_d;
      end
   end

   assign bcd_out   = bcd_out_q;
   assign hex       = hex_q;
   assign busy      = busy_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_pio_bcd_display.sv
// Self-checking bench for pio_bcd_display: directed cases plus random values,
// checked against a decimal-arithmetic reference model.
module tb_pio_bcd_display;

  localparam int DATA_W = 18;
  localparam int DIGITS = 6;

  logic                clk;
  logic                reset_n;
  logic [DATA_W-1:0]   value_in;
  logic                blank_lz;
  logic [4*DIGITS-1:0] bcd_out;
  logic [7*DIGITS-1:0] hex;
  logic                busy;
  logic [1:0]          state_dbg;

  int n_cmp;
  int n_err;
  logic [4*DIGITS-1:0] exp_q[$];

  pio_bcd_display #(
    .DATA_W     (DATA_W),
    .DIGITS     (DIGITS),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .value_in  (value_in),
    .blank_lz  (blank_lz),
    .bcd_out   (bcd_out),
    .hex       (hex),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [4*DIGITS-1:0] model_bcd(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [7*DIGITS-1:0] model_hex(input int unsigned v, input bit blz);
    logic [7*DIGITS-1:0] r;
    int unsigned p;
    logic [6:0] s;
    r = '0;
    p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      if (blz && k > 0 && v < p) s = 7'h00;
      else s = seg_of(int'((v / p) % 10));
      r[7*k +: 7] = ~s;
      p = p * 10;
    end
    return r;
  endfunction

  // driver tasks
  task automatic drive(input int unsigned v, input bit blz);
    @(negedge clk);
    value_in = DATA_W'(v);
    blank_lz = blz;
  endtask

  // Waits for busy to rise and then fall; returns the number of busy samples.
  task automatic wait_idle(output int hi);
    bit seen;
    bit done;
    seen = 0;
    done = 0;
    hi = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (busy) begin
        seen = 1;
        hi++;
      end else if (seen) begin
        done = 1;
      end
    end
    if (!done) check("timeout", 64'(hi), 64'(DATA_W + 1));
  endtask

  task automatic score(input string tag, input int unsigned v, input bit blz);
    logic [4*DIGITS-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'(bcd_out), 64'hDEAD);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_bcd"}, 64'(bcd_out), 64'(e));
      check({tag, "_hex"}, 64'(hex), 64'(model_hex(v, blz)));
    end
  endtask

  task automatic convert(input string tag, input int unsigned v, input bit blz);
    int hi;
    drive(v, blz);
    exp_q.push_back(model_bcd(v));
    wait_idle(hi);
    check({tag, "_latency"}, 64'(hi), 64'(DATA_W + 1));
    score(tag, v, blz);
  endtask

  initial begin
    int hi;
    int unsigned cur;
    int unsigned v;
    bit blz;
    bit busy_seen;
    bit out_moved;
    logic [4*DIGITS-1:0] hold_bcd;
    logic [7*DIGITS-1:0] hold_hex;

    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    value_in = '0;
    blank_lz = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_bcd", 64'(bcd_out), 64'h0);
    check("rst_hex", 64'(hex), 64'({7*DIGITS{1'b1}}));
    check("rst_busy", 64'(busy), 64'h0);

    // forced conversion of value 0 after reset release
    reset_n = 1'b1;
    exp_q.push_back(model_bcd(0));
    wait_idle(hi);
    check("init_latency", 64'(hi), 64'(DATA_W + 1));
    check("init_hex_d0", 64'(hex[6:0]), 64'(7'b1000000));
    check("init_hex_hi", 64'(hex[41:7]), 64'({35{1'b1}}));
    score("init", 0, 1);
    cur = 0;

    convert("max", 262143, 0);
    check("max_bcd_const", 64'(bcd_out), 64'h262143);
    convert("v1234", 1234, 1);
    check("v1234_d0", 64'(hex[6:0]), 64'(7'b0011001));
    check("v1234_d5d4", 64'(hex[41:28]), 64'({14{1'b1}}));

    // back-to-back: 999 arrives 5 cycles into converting 100
    drive(100, 1);
    exp_q.push_back(model_bcd(100));
    repeat (5) @(negedge clk);
    value_in = DATA_W'(999);
    exp_q.push_back(model_bcd(999));
    wait_idle(hi);
    score("b2b_first", 100, 1);
    @(negedge clk);
    check("b2b_gap", 64'(busy), 64'h1);
    wait_idle(hi);
    score("b2b_second", 999, 1);
    cur = 999;

    // unchanged value: no conversion, stable outputs
    hold_bcd = bcd_out;
    hold_hex = hex;
    busy_seen = 0;
    out_moved = 0;
    for (int i = 0; i < 100; i++) begin
      drive(cur, 1);
      if (busy) busy_seen = 1;
      if (bcd_out !== hold_bcd || hex !== hold_hex) out_moved = 1;
    end
    check("hold_busy", 64'(busy_seen), 64'h0);
    check("hold_stable", 64'(out_moved), 64'h0);
    check("hold_bcd", 64'(bcd_out), 64'(model_bcd(999)));

    // random values
    for (int n = 0; n < 20; n++) begin
      v = $urandom_range(0, 262143);
      if (v == cur) v = (v + 1) % 262144;
      blz = 1'($urandom_range(0, 1));
      convert("rand", v, blz);
      cur = v;
    end
    if (cur != 0) begin
      convert("zero_noblank", 0, 0);
      cur = 0;
    end
    convert("v10_blank", 10, 1);

    // reset 7 cycles into converting 4321
    drive(4321, 1);
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_bcd", 64'(bcd_out), 64'h0);
    check("midrst_hex", 64'(hex), 64'({7*DIGITS{1'b1}}));
    check("midrst_busy", 64'(busy), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(model_bcd(4321));
    wait_idle(hi);
    check("midrst_latency", 64'(hi), 64'(DATA_W + 1));
    score("midrst", 4321, 1);
    busy_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1;
    end
    check("midrst_single", 64'(busy_seen), 64'h0);
    check("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
